ps2_key_event_rx: RTL and testbench

//   PS/2 keyboard receiver. Oversamples PS2_CLK/PS2_DATA on the system clock, frames 11-bit packets, checks parity and stop bit.

---
 rtl/ps2_key_event_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_rx
//  Description : PS/2 keyboard receiver. Synchronises and glitch-filters the
//                PS/2 clock, frames 11-bit packets with parity/stop checks,
//                folds E0/F0 prefixes into key events and buffers them in a
//                first-word-fall-through FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst_l,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic          evt_valid,
  output logic [7:0]    evt_code,
  output logic          evt_break,
  output logic          evt_ext,
  output logic [CW-1:0] evt_count,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Reset release is synchronised so every flop leaves reset on the same edge
  logic [1:0] rst_sync;
  logic       rst_n;

  // Reset synchroniser: asserts immediately, releases after two clock edges
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Line synchronisers; both lines idle high so they reset to 1
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sclk;
  logic                   sdata;

  // Shift raw PS/2 lines through the synchroniser chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end
  assign sclk  = clk_sync[SYNC_STAGES-1];
  assign sdata = data_sync[SYNC_STAGES-1];

  // Glitch filter: the filtered clock flips only after FILTER_LEN
  // consecutive synced samples disagree with it
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          filt_flip;
  logic          fall;

  assign filt_flip = (sclk != filt) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && filt;

  // Filter counter and filtered clock state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (sclk == filt) begin
      fcnt <= '0;
    end else if (filt_flip) begin
      filt <= sclk;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // Frame state
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          stop_fall;
  logic          frame_ev;
  logic          parity_ev;
  logic          byte_ok;
  logic          push;

  assign timeout   = (state != ST_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign stop_fall = fall && (state == ST_STOP);
  assign frame_ev  = (fall && (state == ST_IDLE) && sdata) || (stop_fall && !sdata) || timeout;
  assign parity_ev = stop_fall && sdata && !(^{shreg, par});
  assign byte_ok   = stop_fall && sdata && (^{shreg, par});
  assign push      = byte_ok && (shreg != 8'hE0) && (shreg != 8'hF0);

  // Frame FSM: advances on filtered falling edges, bails out on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      par    <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (fall || (state == ST_IDLE)) tcnt <= '0;
      else                            tcnt <= tcnt + 1'b1;

      if (timeout) begin
        state <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!sdata) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg  <= {sdata, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= sdata;
            state <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Prefix flags waiting for the code byte they qualify
  logic pend_ext;
  logic pend_brk;

  // Prefix decoder: E0/F0 arm flags, a code byte consumes them, errors drop them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (frame_ev || parity_ev) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (byte_ok) begin
      if (shreg == 8'hE0) begin
        pend_ext <= 1'b1;
      end else if (shreg == 8'hF0) begin
        pend_brk <= 1'b1;
      end else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end

  // Event FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr;
  logic [9:0]    head;

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = rd_en && (count != '0);
  assign wr   = push && (!full || pop);

  // Storage array; contents are only observed while the entry is valid
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {pend_ext, pend_brk, shreg};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= parity_ev | (parity_err & ~clr_err);
      frame_err  <= frame_ev  | (frame_err  & ~clr_err);
      overflow   <= (push && full && !pop) | (overflow & ~clr_err);
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_break = evt_valid & head[8];
  assign evt_ext   = evt_valid & head[9];
  assign evt_count = count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_event_rx
//  Description : Self-checking bench for ps2_key_event_rx. A queue-based
//                model of key events and error flags is compared against the
//                DUT every cycle while the PS/2 lines are quiet.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int FIFO_DEPTH  = 8;
  localparam int CW          = 4;
  localparam int HALF        = 20;

  logic          clk = 1'b0;
  logic          arst_l = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_break;
  logic          evt_ext;
  logic [CW-1:0] evt_count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  ps2_key_event_rx #(
    .SYNC_STAGES(2),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .arst_l    (arst_l),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .evt_count (evt_count),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: queue of {ext, brk, code} plus sticky flags and pending prefixes
  logic [9:0] mq [$];
  bit m_ext, m_brk, m_perr, m_ferr, m_ovf;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle comparison against the model while the lines are quiet
  always @(negedge clk) begin
    if (chk_en) begin
      logic [9:0] h;
      h = (mq.size() > 0) ? mq[0] : 10'h000;
      cmp("m_valid",  evt_valid,  mq.size() > 0);
      cmp("m_count",  evt_count,  mq.size());
      cmp("m_code",   evt_code,   h[7:0]);
      cmp("m_break",  evt_break,  h[8]);
      cmp("m_ext",    evt_ext,    h[9]);
      cmp("m_perr",   parity_err, m_perr);
      cmp("m_ferr",   frame_err,  m_ferr);
      cmp("m_ovf",    overflow,   m_ovf);
    end
  end

  // Drive one PS/2 frame. nbits<8 stops after that many data bits; with
  // wait_to the bench then idles past the timeout, otherwise it returns with
  // checking disabled (used before a mid-frame reset).
  task automatic send(input logic [7:0] b, input bit par_good, input bit stop_ok,
                      input int nbits, input bit wait_to, input bit glitch);
    logic        p;
    logic [10:0] bits;
    int          nb;
    p    = par_good ? ~^b : ^b;
    bits = {stop_ok, p, b, 1'b0};
    nb   = (nbits >= 8) ? 11 : 1 + nbits;
    chk_en = 1'b0;
    for (int i = 0; i < nb; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 3) begin
        tick(6);
        ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1;
        tick(HALF - 9);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b0;
      if (glitch && i == 5) begin
        tick(12);
        ps2_clk = 1'b1; tick(3); ps2_clk = 1'b0;
        tick(HALF - 15);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits < 8) begin
      if (!wait_to) return;
      tick(TIMEOUT_CYC + 60);
      m_ferr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      tick(30);
      if (!stop_ok) begin
        m_ferr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (!par_good) begin
        m_perr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        if (mq.size() < FIFO_DEPTH) mq.push_back({m_ext, m_brk, b});
        else                        m_ovf = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
    chk_en = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 1'b1, 1'b1, 8, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    #1 rd_en = 1'b0;
    tick(1);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    @(posedge clk);
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    #1 clr_err = 1'b0;
    tick(1);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  logic [7:0] codes [9];
  logic [7:0] popped [8];

  initial begin
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    model_reset();
    tick(5);
    cmp("rst_valid", evt_valid, 1'b0);
    cmp("rst_count", evt_count, 0);
    cmp("rst_ferr",  frame_err, 1'b0);
    arst_l = 1'b1;
    tick(5);
    chk_en = 1'b1;
    tick(5);

    // Plain make code
    good(8'h1C);
    cmp("t1_code",  evt_code,  8'h1C);
    cmp("t1_count", evt_count, 1);
    cmp("t1_brk",   evt_break, 1'b0);
    cmp("t1_err",   {parity_err, frame_err, overflow}, 3'b000);
    pop_one();
    cmp("t1_empty", evt_valid, 1'b0);

    // Break and extended-break sequences
    good(8'hF0);
    cmp("t2_f0_none", evt_count, 0);
    good(8'h1C);
    cmp("t2_code", evt_code, 8'h1C);
    cmp("t2_brk",  {evt_ext, evt_break}, 2'b01);
    pop_one();
    good(8'hE0); good(8'hF0); good(8'h75);
    cmp("t2_code2", evt_code, 8'h75);
    cmp("t2_extbrk", {evt_ext, evt_break}, 2'b11);
    cmp("t2_count2", evt_count, 1);
    pop_one();

    // Parity error, clear, recovery
    send(8'h1C, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    cmp("t3_perr", parity_err, 1'b1);
    cmp("t3_none", evt_count, 0);
    clear_errs();
    cmp("t3_clr", parity_err, 1'b0);
    good(8'h1C);
    cmp("t3_good", evt_code, 8'h1C);
    pop_one();

    // Timeout after a prefix drops the prefix; long idle gives no error
    good(8'hE0);
    send(8'h1C, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    cmp("t4_ferr", frame_err, 1'b1);
    good(8'h1C);
    cmp("t4_ext",  evt_ext, 1'b0);
    cmp("t4_code", evt_code, 8'h1C);
    pop_one();
    clear_errs();
    tick(TIMEOUT_CYC + 50);
    cmp("t4_idle", frame_err, 1'b0);
    // Bad stop bit
    send(8'h1C, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    cmp("t4_stop", {frame_err, evt_valid}, 2'b10);
    clear_errs();

    // Overflow and in-order drain with RD_EN held
    for (int i = 0; i < 9; i++) good(codes[i]);
    cmp("t5_count", evt_count, 8);
    cmp("t5_ovf",   overflow,  1'b1);
    cmp("t5_head",  evt_code,  8'h15);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      popped[i] = evt_code;
      @(posedge clk);
      if (mq.size() > 0) void'(mq.pop_front());
      #1;
    end
    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) cmp("t5_order", popped[i], codes[i]);
    tick(3);
    cmp("t5_empty", evt_count, 0);
    clear_errs();

    // Glitch rejection, then reset mid-frame with a pending prefix
    send(8'h1C, 1'b1, 1'b1, 8, 1'b0, 1'b1);
    cmp("t6_glitch", evt_code, 8'h1C);
    good(8'hE0);
    send(8'h1C, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    arst_l = 1'b0;
    model_reset();
    chk_en = 1'b1;
    tick(3);
    cmp("t6_rst", {evt_valid, evt_code, evt_break, evt_ext, evt_count,
                   parity_err, frame_err, overflow}, 0);
    arst_l = 1'b1;
    tick(5);
    good(8'h2C);
    cmp("t6_code",  evt_code, 8'h2C);
    cmp("t6_ext",   {evt_ext, evt_break}, 2'b00);
    cmp("t6_count", evt_count, 1);
    pop_one();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
